// File: rtl/alu_issue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_issue
//
// Issue/writeback stage around an external 16-bit combinational ALU.
//
// Instructions arrive over a valid/ready handshake. Operands are read from an
// 8x16 register file, with bypass from the two in-flight stages. The stage
// registers A/B/F/Cin toward the ALU (stage E). It captures Result/Status one
// cycle later (stage W), then commits them to the register file and the flags
// register through a backpressured writeback port.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid/instr_ready    instruction handshake
//   instr_op                   ALU opcode, or LDI (5'b11000)
//   instr_rd/rs1/rs2           destination, source A, source B
//   instr_imm                  immediate, used by LDI only
//   alu_a/alu_b/alu_f/alu_cin  registered operands, opcode and carry to the ALU
//   alu_result/alu_status      ALU outputs, status = {CF, ZF, NF, VF, PF, AF}
//   wb_valid/wb_ready          writeback handshake
//   wb_rd/wb_data              writeback destination and data
//   flags                      committed flags register
//   dbg_addr/dbg_data          combinational read of the committed register file
// -----------------------------------------------------------------------------
module alu_issue #(
    parameter int NREGS = 8,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [4:0]   instr_op,
    input  logic [2:0]   instr_rd,
    input  logic [2:0]   instr_rs1,
    input  logic [2:0]   instr_rs2,
    input  logic [W-1:0] instr_imm,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [4:0]   alu_f,
    output logic         alu_cin,
    input  logic [W-1:0] alu_result,
    input  logic [5:0]   alu_status,
    output logic         wb_valid,
    input  logic         wb_ready,
    output logic [2:0]   wb_rd,
    output logic [W-1:0] wb_data,
    output logic [5:0]   flags,
    input  logic [2:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);

    localparam logic [4:0] OP_LDI = 5'b11000;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [W-1:0] regs_q [NREGS];
    logic [5:0]   flags_q;
    logic [5:0]   flags_d;

    // ------------------------------------------------------------------
    // Stage E: registers driving the ALU plus the bookkeeping for them
    // ------------------------------------------------------------------
    logic [W-1:0] alu_a_q,   alu_a_d;
    logic [W-1:0] alu_b_q,   alu_b_d;
    logic [4:0]   alu_f_q,   alu_f_d;
    logic         alu_cin_q, alu_cin_d;
    logic         e_valid_q, e_valid_d;
    logic [2:0]   e_rd_q,    e_rd_d;
    logic         e_ldi_q,   e_ldi_d;
    logic [W-1:0] e_imm_q,   e_imm_d;

    // ------------------------------------------------------------------
    // Stage W: captured result waiting for the writeback consumer
    // ------------------------------------------------------------------
    logic         wb_valid_q, wb_valid_d;
    logic [2:0]   wb_rd_q,    wb_rd_d;
    logic [W-1:0] wb_data_q,  wb_data_d;
    logic [5:0]   w_status_q, w_status_d;
    logic         w_ldi_q,    w_ldi_d;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic         advance;
    logic         accept;
    logic         commit;
    logic         op_legal;
    logic         op_is_ldi;
    logic [W-1:0] e_value;
    logic [W-1:0] rs1_val;
    logic [W-1:0] rs2_val;
    logic         cin_fwd;

    // Both stages move together; W only blocks when it holds an
    // uncommitted result that the consumer is refusing.
    assign advance     = !wb_valid_q || wb_ready;
    assign instr_ready = advance;
    assign accept      = instr_valid && advance;
    assign commit      = wb_valid_q && wb_ready;

    assign op_is_ldi = (instr_op == OP_LDI);

    // Opcode decode: anything outside these groups is accepted and dropped.
    always_comb begin
        op_legal = 1'b0;
        casez (instr_op)
            5'b00001,
            5'b00011,
            5'b001??,
            5'b010??,
            5'b10???,
            5'b11000: op_legal = 1'b1;
            default:  op_legal = 1'b0;
        endcase
    end

    // Value that the instruction currently in E will write back. For LDI the
    // ALU is still driven but its output is not used.
    assign e_value = e_ldi_q ? e_imm_q : alu_result;

    // Operand bypass: the newest in-flight producer wins. Because W is also
    // checked, a commit on the same edge as an accept never relies on the
    // register file's read-during-write behaviour.
    assign rs1_val = (e_valid_q  && (e_rd_q  == instr_rs1)) ? e_value   :
                     (wb_valid_q && (wb_rd_q == instr_rs1)) ? wb_data_q :
                     regs_q[instr_rs1];

    assign rs2_val = (e_valid_q  && (e_rd_q  == instr_rs2)) ? e_value   :
                     (wb_valid_q && (wb_rd_q == instr_rs2)) ? wb_data_q :
                     regs_q[instr_rs2];

    // Carry bypass: LDI does not produce flags, so the nearest older
    // flag-producing instruction provides CF. If there is none, the
    // committed CF is used.
    always_comb begin
        if (e_valid_q && !e_ldi_q) begin
            cin_fwd = alu_status[5];
        end else if (wb_valid_q && !w_ldi_q) begin
            cin_fwd = w_status_q[5];
        end else begin
            cin_fwd = flags_q[5];
        end
    end

    // ------------------------------------------------------------------
    // Pipeline next state
    // ------------------------------------------------------------------
    always_comb begin
        // Hold everything unless the pipeline advances.
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_f_d    = alu_f_q;
        alu_cin_d  = alu_cin_q;
        e_valid_d  = e_valid_q;
        e_rd_d     = e_rd_q;
        e_ldi_d    = e_ldi_q;
        e_imm_d    = e_imm_q;
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        w_status_d = w_status_q;
        w_ldi_d    = w_ldi_q;

        if (advance) begin
            // W takes whatever E holds, including a bubble.
            wb_valid_d = e_valid_q;
            wb_rd_d    = e_rd_q;
            wb_data_d  = e_value;
            w_status_d = alu_status;
            w_ldi_d    = e_ldi_q;

            // Illegal opcodes are consumed here and simply leave a bubble.
            e_valid_d = accept && op_legal;
            if (accept && op_legal) begin
                e_rd_d    = instr_rd;
                e_ldi_d   = op_is_ldi;
                e_imm_d   = instr_imm;
                alu_a_d   = rs1_val;
                alu_b_d   = rs2_val;
                alu_f_d   = instr_op;
                alu_cin_d = cin_fwd;
            end
        end
    end

    // LDI results never touch the flags.
    always_comb begin
        flags_d = flags_q;
        if (commit && !w_ldi_q) begin
            flags_d = w_status_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_f_q    <= '0;
            alu_cin_q  <= 1'b0;
            e_valid_q  <= 1'b0;
            e_rd_q     <= '0;
            e_ldi_q    <= 1'b0;
            e_imm_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            w_status_q <= '0;
            w_ldi_q    <= 1'b0;
            flags_q    <= '0;
        end else begin
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_f_q    <= alu_f_d;
            alu_cin_q  <= alu_cin_d;
            e_valid_q  <= e_valid_d;
            e_rd_q     <= e_rd_d;
            e_ldi_q    <= e_ldi_d;
            e_imm_q    <= e_imm_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            w_status_q <= w_status_d;
            w_ldi_q    <= w_ldi_d;
            flags_q    <= flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Register file: one write port (commit), combinational reads.
    // Every entry resets to zero; r0 is an ordinary register.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regfile
        localparam logic [2:0] IDX = 3'(gi);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs_q[gi] <= '0;
            end else if (commit && (wb_rd_q == IDX)) begin
                regs_q[gi] <= wb_data_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_f    = alu_f_q;
    assign alu_cin  = alu_cin_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign flags    = flags_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_alu_issue
//
// Bench for alu_issue. A behavioural 16-bit ALU drives alu_result/alu_status
// from the DUT's registered ALU outputs. A program-order reference model holds
// the architectural registers and flags, plus a queue of expected writebacks.
// A negedge monitor compares every commit, dbg_data and flags against that
// model. Scenario tasks add timing-specific checks of their own.
// -----------------------------------------------------------------------------
module tb_alu_issue;

    localparam logic [4:0] OP_LDI = 5'b11000;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_ADC = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b10000;
    localparam logic [4:0] OP_RCL = 5'b10110;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  instr_op;
    logic [2:0]  instr_rd;
    logic [2:0]  instr_rs1;
    logic [2:0]  instr_rs2;
    logic [15:0] instr_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_f;
    logic        alu_cin;
    logic [15:0] alu_result;
    logic [5:0]  alu_status;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [5:0]  flags;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    alu_issue #(.NREGS(8), .W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_imm   (instr_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_f       (alu_f),
        .alu_cin     (alu_cin),
        .alu_result  (alu_result),
        .alu_status  (alu_status),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flags       (flags),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Behavioural ALU: returns {Result, CF, ZF, NF, VF, PF, AF}
    // ------------------------------------------------------------------
    function automatic logic [21:0] alu_ref(input logic [4:0] f, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
        logic [16:0] s;
        logic [15:0] r, op2, x;
        logic cf, vf, af, ci, add_op, sub_op;
        s = '0; r = '0; op2 = b; x = '0; cf = 1'b0; vf = 1'b0; af = 1'b0;
        ci = 1'b0; add_op = 1'b0; sub_op = 1'b0;
        case (f)
            5'b00001: begin add_op = 1'b1; op2 = 16'd1; end
            5'b00011: begin sub_op = 1'b1; op2 = 16'd1; end
            5'b00100: add_op = 1'b1;
            5'b00101: begin add_op = 1'b1; ci = c; end
            5'b00110: sub_op = 1'b1;
            5'b00111: begin sub_op = 1'b1; ci = c; end
            5'b01000: r = a & b;
            5'b01001: r = a | b;
            5'b01010: r = a ^ b;
            5'b01011: r = ~a;
            5'b10000, 5'b10010: begin r = {a[14:0], 1'b0}; cf = a[15]; end
            5'b10001: begin r = {1'b0, a[15:1]};  cf = a[0];  end
            5'b10011: begin r = {a[15], a[15:1]}; cf = a[0];  end
            5'b10100: begin r = {a[14:0], a[15]}; cf = a[15]; end
            5'b10101: begin r = {a[0], a[15:1]};  cf = a[0];  end
            5'b10110: begin r = {a[14:0], c};     cf = a[15]; end
            5'b10111: begin r = {c, a[15:1]};     cf = a[0];  end
            default:  r = '0;
        endcase
        if (add_op) begin
            s  = {1'b0, a} + {1'b0, op2} + {16'd0, ci};
            r  = s[15:0];
            cf = s[16];
            vf = (a[15] == op2[15]) && (r[15] != a[15]);
        end else if (sub_op) begin
            s  = {1'b0, a} - {1'b0, op2} - {16'd0, ci};
            r  = s[15:0];
            cf = s[16];
            vf = (a[15] != op2[15]) && (r[15] != a[15]);
        end
        x = a ^ op2 ^ r;
        if (add_op || sub_op) af = x[4];
        return {r, cf, (r == 16'd0), r[15], vf, ~^r[7:0], af};
    endfunction

    assign {alu_result, alu_status} = alu_ref(alu_f, alu_a, alu_b, alu_cin);

    function automatic bit is_legal(input logic [4:0] op);
        int v;
        v = int'(op);
        return (v == 1) || (v == 3) || (v >= 4 && v <= 11) || (v >= 16 && v <= 23);
    endfunction

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] data;
        logic        ldi;
        logic [5:0]  st;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] arch_regs [8];    // program order, updated at accept
    logic [5:0]  arch_flags;
    logic [15:0] cm_regs [8];      // committed, updated at writeback
    logic [5:0]  cm_flags;
    int          acc_log[$];
    int          cm_log[$];
    bit          mon_en = 1'b0;
    exp_t        mon_e;
    logic [21:0] mon_res;

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            arch_regs[i] = '0;
            cm_regs[i]   = '0;
        end
        arch_flags = '0;
        cm_flags   = '0;
        exp_q.delete();
        acc_log.delete();
        cm_log.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            n_total++;
            if (dbg_data !== cm_regs[dbg_addr])
                $display("FAIL mon_dbg: r%0d got %h want %h", dbg_addr, dbg_data, cm_regs[dbg_addr]);
            else n_pass++;
            n_total++;
            if (flags !== cm_flags)
                $display("FAIL mon_flags: got %b want %b", flags, cm_flags);
            else n_pass++;

            if (wb_valid && wb_ready) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL mon_wb_extra: got rd=%0d data=%h want no writeback", wb_rd, wb_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (wb_rd !== mon_e.rd || wb_data !== mon_e.data)
                        $display("FAIL mon_wb: got rd=%0d data=%h want rd=%0d data=%h",
                                 wb_rd, wb_data, mon_e.rd, mon_e.data);
                    else n_pass++;
                    cm_regs[mon_e.rd] = mon_e.data;
                    if (!mon_e.ldi) cm_flags = mon_e.st;
                end
                cm_log.push_back(cyc);
            end

            if (instr_valid && instr_ready) begin
                acc_log.push_back(cyc);
                if (instr_op == OP_LDI) begin
                    arch_regs[instr_rd] = instr_imm;
                    mon_e.rd = instr_rd; mon_e.data = instr_imm; mon_e.ldi = 1'b1; mon_e.st = '0;
                    exp_q.push_back(mon_e);
                end else if (is_legal(instr_op)) begin
                    mon_res = alu_ref(instr_op, arch_regs[instr_rs1], arch_regs[instr_rs2], arch_flags[5]);
                    arch_regs[instr_rd] = mon_res[21:6];
                    arch_flags = mon_res[5:0];
                    mon_e.rd = instr_rd; mon_e.data = mon_res[21:6]; mon_e.ldi = 1'b0; mon_e.st = mon_res[5:0];
                    exp_q.push_back(mon_e);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (tasks enter and leave just after a rising edge)
    // ------------------------------------------------------------------
    task automatic drive(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] imm);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd;
        instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        mon_en = 1'b0;
        wb_ready = 1'b1;
        instr_valid = 1'b1; instr_op = OP_LDI; instr_rd = 3'd1; instr_imm = 16'hBEEF;
        rst_n = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b want 0", wb_valid); else n_pass++;
        n_total++;
        if (flags !== 6'd0) $display("FAIL reset_flags: got %b want 000000", flags); else n_pass++;
        n_total++;
        if ({alu_a, alu_b, alu_f, alu_cin} !== 38'd0)
            $display("FAIL reset_alu_regs: got a=%h b=%h f=%b cin=%b want all 0", alu_a, alu_b, alu_f, alu_cin);
        else n_pass++;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (instr_ready !== 1'b1) $display("FAIL reset_instr_ready: got %b want 1", instr_ready); else n_pass++;
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a); #1;
            n_total++;
            if (dbg_data !== 16'h0000) $display("FAIL reset_dbg: r%0d got %h want 0000", a, dbg_data);
            else n_pass++;
        end
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    task automatic test_add_overflow();
        acc_log.delete(); cm_log.delete();
        drive(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h7FFF);
        drive(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0001);
        drive(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0000);
        idle(4);
        n_total++;
        if (acc_log.size() != 3 || cm_log.size() != 3)
            $display("FAIL add_counts: got accepts=%0d commits=%0d want 3/3", acc_log.size(), cm_log.size());
        else n_pass++;
        if (acc_log.size() == 3 && cm_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (cm_log[i] - acc_log[i] != 2)
                    $display("FAIL add_latency: instr %0d got %0d cycles want 2", i, cm_log[i] - acc_log[i]);
                else n_pass++;
            end
            n_total++;
            if (cm_log[2] - cm_log[0] != 2)
                $display("FAIL add_consecutive: got span %0d want 2", cm_log[2] - cm_log[0]);
            else n_pass++;
        end
        dbg_addr = 3'd3; #1;
        n_total++;
        if (dbg_data !== 16'h8000) $display("FAIL add_r3: got %h want 8000", dbg_data); else n_pass++;
        n_total++;
        if (flags[5:2] !== 4'b0011) $display("FAIL add_flags: got CZNV=%b want 0011", flags[5:2]); else n_pass++;
    endtask

    task automatic test_carry_fwd();
        drive(OP_LDI, 3'd1, 3'd0, 3'd0, 16'hFFFF);
        drive(OP_ADD, 3'd2, 3'd1, 3'd1, 16'h0000);
        drive(OP_ADC, 3'd3, 3'd0, 3'd0, 16'h0000);
        n_total++;
        if (alu_cin !== 1'b1 || alu_f !== OP_ADC)
            $display("FAIL carry_cin: got cin=%b f=%b want cin=1 f=00101", alu_cin, alu_f);
        else n_pass++;
        idle(4);
        dbg_addr = 3'd2; #1;
        n_total++;
        if (dbg_data !== 16'hFFFE) $display("FAIL carry_r2: got %h want fffe", dbg_data); else n_pass++;
        dbg_addr = 3'd3; #1;
        n_total++;
        if (dbg_data !== 16'h0001) $display("FAIL carry_r3: got %h want 0001", dbg_data); else n_pass++;
    endtask

    task automatic test_shift_carry();
        drive(OP_LDI, 3'd5, 3'd0, 3'd0, 16'h8001);
        drive(OP_SHL, 3'd6, 3'd5, 3'd0, 16'h0000);
        drive(OP_RCL, 3'd7, 3'd6, 3'd0, 16'h0000);
        n_total++;
        if (alu_cin !== 1'b1) $display("FAIL shift_cin: got %b want 1", alu_cin); else n_pass++;
        idle(4);
        dbg_addr = 3'd6; #1;
        n_total++;
        if (dbg_data !== 16'h0002) $display("FAIL shift_r6: got %h want 0002", dbg_data); else n_pass++;
        dbg_addr = 3'd7; #1;
        n_total++;
        if (dbg_data !== 16'h0005) $display("FAIL shift_r7: got %h want 0005", dbg_data); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [15:0] snap;
        wb_ready = 1'b1;
        cm_log.delete();
        drive(OP_LDI, 3'd1, 3'd0, 3'd0, 16'hA5A5);
        drive(OP_ADD, 3'd2, 3'd1, 3'd1, 16'h0000);
        wb_ready = 1'b0;
        dbg_addr = 3'd1;
        snap = cm_regs[1];
        instr_valid = 1'b1; instr_op = OP_LDI; instr_rd = 3'd0; instr_imm = 16'h1111;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if (instr_ready !== 1'b0) $display("FAIL bp_instr_ready: got %b want 0", instr_ready); else n_pass++;
            n_total++;
            if (wb_valid !== 1'b1 || wb_rd !== 3'd1 || wb_data !== 16'hA5A5)
                $display("FAIL bp_wb_hold: got v=%b rd=%0d data=%h want v=1 rd=1 data=a5a5", wb_valid, wb_rd, wb_data);
            else n_pass++;
            n_total++;
            if (alu_f !== OP_ADD || alu_a !== 16'hA5A5)
                $display("FAIL bp_alu_hold: got f=%b a=%h want f=00100 a=a5a5", alu_f, alu_a);
            else n_pass++;
            n_total++;
            if (dbg_data !== snap) $display("FAIL bp_dbg: got %h want %h", dbg_data, snap); else n_pass++;
            @(posedge clk); #1;
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        idle(4);
        n_total++;
        if (cm_log.size() < 2 || cm_log[1] - cm_log[0] != 1)
            $display("FAIL bp_release: got %0d commits / not consecutive want 2 consecutive", cm_log.size());
        else n_pass++;
        dbg_addr = 3'd2; #1;
        n_total++;
        if (dbg_data !== 16'h4B4A) $display("FAIL bp_r2: got %h want 4b4a", dbg_data); else n_pass++;
    endtask

    task automatic test_illegal();
        logic [5:0] fl;
        idle(3);
        fl = cm_flags;
        cm_log.delete();
        drive(OP_LDI, 3'd4, 3'd0, 3'd0, 16'h1234);
        instr_valid = 1'b1; instr_op = 5'b00000; instr_rd = 3'd4; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
        @(negedge clk);
        n_total++;
        if (instr_ready !== 1'b1) $display("FAIL illegal_ready: got %b want 1", instr_ready); else n_pass++;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        idle(5);
        n_total++;
        if (cm_log.size() != 1) $display("FAIL illegal_wb_count: got %0d want 1", cm_log.size()); else n_pass++;
        dbg_addr = 3'd4; #1;
        n_total++;
        if (dbg_data !== 16'h1234) $display("FAIL illegal_r4: got %h want 1234", dbg_data); else n_pass++;
        n_total++;
        if (flags !== fl) $display("FAIL illegal_flags: got %b want %b", flags, fl); else n_pass++;
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 600; i++) begin
            instr_valid = ($urandom_range(0, 9) < 8);
            r = $urandom_range(0, 99);
            instr_op  = (r < 20) ? OP_LDI : 5'($urandom_range(0, 31));
            instr_rd  = 3'($urandom_range(0, 7));
            instr_rs1 = 3'($urandom_range(0, 7));
            instr_rs2 = 3'($urandom_range(0, 7));
            instr_imm = 16'($urandom);
            wb_ready  = ($urandom_range(0, 3) != 0);
            dbg_addr  = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        wb_ready = 1'b1;
        idle(4);
        n_total++;
        if (exp_q.size() != 0) $display("FAIL rand_drain: got %0d pending want 0", exp_q.size()); else n_pass++;
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a); #1;
            n_total++;
            if (dbg_data !== arch_regs[a]) $display("FAIL rand_final: r%0d got %h want %h", a, dbg_data, arch_regs[a]);
            else n_pass++;
        end
        n_total++;
        if (flags !== arch_flags) $display("FAIL rand_flags: got %b want %b", flags, arch_flags); else n_pass++;
    endtask

    task automatic test_reset_midop();
        wb_ready = 1'b1;
        drive(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h1111);
        drive(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h2222);
        mon_en = 1'b0;
        rst_n = 1'b0;
        clear_model();
        #1;
        n_total++;
        if (wb_valid !== 1'b0) $display("FAIL midrst_wb_valid: got %b want 0", wb_valid); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(4);
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a); #1;
            n_total++;
            if (dbg_data !== 16'h0000) $display("FAIL midrst_dbg: r%0d got %h want 0000", a, dbg_data);
            else n_pass++;
        end
        n_total++;
        if (flags !== 6'd0) $display("FAIL midrst_flags: got %b want 000000", flags); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
        instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0; wb_ready = 1'b1; dbg_addr = '0;
        #1;
        test_reset();
        test_add_overflow();
        test_carry_fwd();
        test_shift_carry();
        test_backpressure();
        test_illegal();
        test_random();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, want completion before limit");
        $fatal(1, "watchdog");
    end

endmodule
